// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph bytes, pattern decoder and monitor FSM states.
// Used by the button counter, the pattern monitor and their benches.
package seg_pkg;

    // Full bus bytes {a,b,c,d,e,f,g,dp} with dp=0
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic       ok;
        logic [3:0] val;
    } seg_dec_t;

    // dp is ignored; ok=0 for anything that is not one of the 16 hex glyphs
    function automatic seg_dec_t seg_decode(input logic [7:0] pat);
        seg_dec_t r;
        r.ok  = 1'b1;
        r.val = 4'h0;
        case (pat[7:1])
            SEG_0[7:1]: r.val = 4'h0;
            SEG_1[7:1]: r.val = 4'h1;
            SEG_2[7:1]: r.val = 4'h2;
            SEG_3[7:1]: r.val = 4'h3;
            SEG_4[7:1]: r.val = 4'h4;
            SEG_5[7:1]: r.val = 4'h5;
            SEG_6[7:1]: r.val = 4'h6;
            SEG_7[7:1]: r.val = 4'h7;
            SEG_8[7:1]: r.val = 4'h8;
            SEG_9[7:1]: r.val = 4'h9;
            SEG_A[7:1]: r.val = 4'hA;
            SEG_B[7:1]: r.val = 4'hB;
            SEG_C[7:1]: r.val = 4'hC;
            SEG_D[7:1]: r.val = 4'hD;
            SEG_E[7:1]: r.val = 4'hE;
            SEG_F[7:1]: r.val = 4'hF;
            default:    r.ok  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Deglitcher for the segment bus: a byte is accepted once it has been sampled
// STABLE_CYCLES times in a row and differs from the previously accepted byte.
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_i,
    output logic [7:0] acc_byte_o,
    output logic       acc_vld_o
);

    localparam int              CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

    logic [7:0]    seg_q;
    logic [7:0]    last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_vld_q;
    logic          accept;

    // Counter saturates at CNT_MAX, so "reaches" and "seg differs from last" together
    // fire only once per stable run.
    always_comb begin
        if (seg_i != seg_q)
            cnt_d = CW'(1);
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
        accept = (cnt_d == CNT_MAX) && (seg_i != last_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= 8'h00;
            cnt_q     <= '0;
            last_q    <= 8'h00;
            acc_vld_q <= 1'b0;
        end else begin
            seg_q     <= seg_i;
            cnt_q     <= cnt_d;
            acc_vld_q <= accept;
            if (accept)
                last_q <= seg_i;
        end
    end

    assign acc_byte_o = last_q;
    assign acc_vld_o  = acc_vld_q;

endmodule

// File: rtl/seg_pattern_monitor.sv
// Receive-side checker for the counter's 7-segment bus: deglitches, decodes and
// verifies that accepted digits advance by +1 mod MOD.
module seg_pattern_monitor
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MOD           = 10,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       seg,
    output logic [3:0]       digit,
    output logic             dp,
    output logic             blank,
    output logic             digit_valid,
    output logic             step,
    output logic             seq_err,
    output logic             bad_pat,
    output logic [CNT_W-1:0] step_cnt
);

    logic [7:0] acc_byte;
    logic       acc_vld;
    seg_dec_t   dec;

    mon_state_e       state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             dp_q, dp_d;
    logic             blank_q, blank_d;
    logic             dv_q, dv_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       prev7_q, prev7_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .seg_i     (seg),
        .acc_byte_o(acc_byte),
        .acc_vld_o (acc_vld)
    );

    assign dec = seg_decode(acc_byte);

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        dv_d    = 1'b0;
        step_d  = 1'b0;
        err_d   = 1'b0;
        bad_d   = 1'b0;
        cnt_d   = cnt_q;
        prev7_d = prev7_q;
        if (acc_vld) begin
            dp_d = acc_byte[0];
            // A byte differing only in dp is a decimal-point change, not a new symbol
            if (acc_byte[7:1] != prev7_q) begin
                prev7_d = acc_byte[7:1];
                if (dec.ok) begin
                    digit_d = dec.val;
                    blank_d = 1'b0;
                    dv_d    = 1'b1;
                    state_d = TRACK;
                    if (state_q == TRACK) begin
                        if ((int'(dec.val) < MOD) &&
                            (int'(dec.val) == (int'(digit_q) + 1) % MOD)) begin
                            step_d = 1'b1;
                            if (cnt_q != '1)
                                cnt_d = cnt_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (acc_byte[7:1] == SEG_BLANK[7:1]) begin
                    blank_d = 1'b1;
                    state_d = WAIT_FIRST;
                end else begin
                    bad_d   = 1'b1;
                    state_d = WAIT_FIRST;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_FIRST;
            digit_q <= 4'h0;
            dp_q    <= 1'b0;
            blank_q <= 1'b0;
            dv_q    <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
            prev7_q <= 7'h00;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            dv_q    <= dv_d;
            step_q  <= step_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
            prev7_q <= prev7_d;
        end
    end

    assign digit       = digit_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign digit_valid = dv_q;
    assign step        = step_q;
    assign seq_err     = err_q;
    assign bad_pat     = bad_q;
    assign step_cnt    = cnt_q;

endmodule
